// File: rtl/ddr2_init_sequencer.sv
// ddr2_init_sequencer: JEDEC DDR2 power-up/init sequence driving CKE and the command bus until init_done.
// DDR2_INIT_SIM_SHORT_EN shortens the power-up and CKE-high waits to 16/8 cycles for simulation only.
module ddr2_init_sequencer #(
    parameter int BANK_WIDTH = 3,
    parameter int ROW_WIDTH = 14,
    parameter int PWRUP_CYCLES = 40000,
    parameter int CKE_CYCLES = 80,
    parameter int TRP_CYCLES = 4,
    parameter int TMRD_CYCLES = 2,
    parameter int TRFC_CYCLES = 26,
    parameter int DLL_CYCLES = 200,
    parameter logic [ROW_WIDTH-1:0] MR_VAL = 14'h0632,
    parameter logic [ROW_WIDTH-1:0] EMR_VAL = 14'h0044
) (
    input  logic                  clk_0,
    input  logic                  sys_rst_n,
    input  logic                  init_req,
    output logic                  ddr_cke,
    output logic                  ddr_cs_n,
    output logic                  ddr_ras_n,
    output logic                  ddr_cas_n,
    output logic                  ddr_we_n,
    output logic [BANK_WIDTH-1:0] ddr_ba,
    output logic [ROW_WIDTH-1:0]  ddr_addr,
    output logic                  ddr_odt,
    output logic                  init_done
);
`ifdef DDR2_INIT_SIM_SHORT_EN
    localparam int PWR_W = 16;
    localparam int CKE_W = 8;
`else
    localparam int PWR_W = PWRUP_CYCLES;
    localparam int CKE_W = CKE_CYCLES;
`endif
    localparam logic [15:0] PWR_LD = 16'(PWR_W - 1);
    localparam logic [15:0] CKE_LD = 16'(CKE_W - 1);
    localparam logic [15:0] TRP_LD = 16'(TRP_CYCLES - 1);
    localparam logic [15:0] TMRD_LD = 16'(TMRD_CYCLES - 1);
    localparam logic [15:0] TRFC_LD = 16'(TRFC_CYCLES - 1);
    localparam logic [15:0] DLL_LD = 16'(DLL_CYCLES - 1);
    localparam logic [ROW_WIDTH-1:0] A0 = ROW_WIDTH'(1);
    localparam logic [ROW_WIDTH-1:0] A8 = ROW_WIDTH'(256);
    localparam logic [ROW_WIDTH-1:0] A10 = ROW_WIDTH'(1024);
    localparam logic [ROW_WIDTH-1:0] OCD = ROW_WIDTH'(896);
    localparam logic [ROW_WIDTH-1:0] EMR_BASE = EMR_VAL & ~A0 & ~OCD;
    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, LMR = 3'b000, REF = 3'b001;

    typedef enum logic [3:0] {
        PWRUP, CKEHI, PRE1, EMR2, EMR3, EMR_DLL, MR_DLLRST, PRE2,
        REF1, REF2, MR_RUN, EMR_OCDDEF, EMR_OCDEXIT, DLLWAIT, DONE
    } state_t;

    state_t state, state_nx;
    logic [15:0] cnt, cnt_nx, dll_cnt, dll_nx;
    logic [2:0] cmd_nx;
    logic [BANK_WIDTH-1:0] ba_nx;
    logic [ROW_WIDTH-1:0] addr_nx;
    logic enter;

    always_comb begin
        state_nx = state;
        case (state)
            DLLWAIT: state_nx = dll_cnt == 16'd0 ? DONE : DLLWAIT;
            DONE:    state_nx = init_req ? PWRUP : DONE;
            default: state_nx = cnt == 16'd0 ? state_t'(state + 4'd1) : state;
        endcase
        enter = state_nx != state;
        cnt_nx = cnt == 16'd0 ? 16'd0 : cnt - 16'd1;
        dll_nx = dll_cnt == 16'd0 ? 16'd0 : dll_cnt - 16'd1;
        cmd_nx = NOP;
        ba_nx = '0;
        addr_nx = '0;
        if (enter) begin
            case (state_nx)
                PWRUP:       cnt_nx = PWR_LD;
                CKEHI:       cnt_nx = CKE_LD;
                PRE1, PRE2:  begin cnt_nx = TRP_LD; cmd_nx = PRE; addr_nx = A10; end
                REF1, REF2:  begin cnt_nx = TRFC_LD; cmd_nx = REF; end
                DLLWAIT, DONE: cnt_nx = 16'd0;
                default:     begin cnt_nx = TMRD_LD; cmd_nx = LMR; end
            endcase
            case (state_nx)
                EMR2:        ba_nx = BANK_WIDTH'(2);
                EMR3:        ba_nx = BANK_WIDTH'(3);
                EMR_DLL:     begin ba_nx = BANK_WIDTH'(1); addr_nx = EMR_BASE; end
                MR_DLLRST:   begin addr_nx = MR_VAL | A8; dll_nx = DLL_LD; end
                MR_RUN:      addr_nx = MR_VAL & ~A8;
                EMR_OCDDEF:  begin ba_nx = BANK_WIDTH'(1); addr_nx = EMR_BASE | OCD; end
                EMR_OCDEXIT: begin ba_nx = BANK_WIDTH'(1); addr_nx = EMR_BASE; end
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk_0 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= PWRUP;
            cnt <= PWR_LD;
            dll_cnt <= '0;
            ddr_cke <= 1'b0;
            ddr_cs_n <= 1'b1;
            {ddr_ras_n, ddr_cas_n, ddr_we_n} <= NOP;
            ddr_ba <= '0;
            ddr_addr <= '0;
            ddr_odt <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            dll_cnt <= dll_nx;
            ddr_cke <= state_nx != PWRUP;
            ddr_cs_n <= state_nx == PWRUP;
            {ddr_ras_n, ddr_cas_n, ddr_we_n} <= cmd_nx;
            ddr_ba <= ba_nx;
            ddr_addr <= addr_nx;
            ddr_odt <= 1'b0;
            init_done <= state_nx == DONE;
        end
    end
endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// tb_ddr2_init_sequencer: command-trace scoreboard for the default and a short-timing instance.
module tb_ddr2_init_sequencer;
    typedef struct packed {
        logic [2:0]  cmd;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic [31:0] gap;
    } ent_t;

    localparam logic [23:0] RST_OUT = {1'b0, 1'b1, 3'b111, 3'b000, 14'h0, 1'b0, 1'b0};

    logic clk_0 = 1'b0;
    logic rst0 = 1'b0, rst1 = 1'b0, req0 = 1'b0, req1 = 1'b0, sel = 1'b1;
    logic cke0, cs0, ras0, cas0, we0, odt0, done0;
    logic cke1, cs1, ras1, cas1, we1, odt1, done1;
    logic [2:0] ba0, ba1;
    logic [13:0] addr0, addr1;
    logic [23:0] ob0, ob1, m;
    int cyc = 0, checks = 0, fails = 0, ncmd = 0, last_cyc = 0, mr_cyc = 0, r = 0;
    logic cke_prev = 1'b0;
    ent_t exp_q[$];

    always #5 clk_0 = ~clk_0;
    always @(posedge clk_0) cyc <= cyc + 1;

    ddr2_init_sequencer u0 (
        .clk_0(clk_0), .sys_rst_n(rst0), .init_req(req0), .ddr_cke(cke0), .ddr_cs_n(cs0),
        .ddr_ras_n(ras0), .ddr_cas_n(cas0), .ddr_we_n(we0), .ddr_ba(ba0), .ddr_addr(addr0),
        .ddr_odt(odt0), .init_done(done0)
    );
    ddr2_init_sequencer #(.PWRUP_CYCLES(100), .CKE_CYCLES(20), .DLL_CYCLES(10)) u1 (
        .clk_0(clk_0), .sys_rst_n(rst1), .init_req(req1), .ddr_cke(cke1), .ddr_cs_n(cs1),
        .ddr_ras_n(ras1), .ddr_cas_n(cas1), .ddr_we_n(we1), .ddr_ba(ba1), .ddr_addr(addr1),
        .ddr_odt(odt1), .init_done(done1)
    );

    assign ob0 = {cke0, cs0, ras0, cas0, we0, ba0, addr0, odt0, done0};
    assign ob1 = {cke1, cs1, ras1, cas1, we1, ba1, addr1, odt1, done1};
    assign m = sel ? ob1 : ob0;

    // Each issued command pops the next expected entry; gap is measured from the previous command or CKE rise.
    always @(negedge clk_0) begin
        ent_t e, o;
        if (m[23] && !cke_prev) last_cyc = cyc;
        cke_prev = m[23];
        if (!m[22] && m[21:19] != 3'b111) begin
            ncmd++;
            o = '{m[21:19], m[18:16], m[15:2], 32'(cyc - last_cyc)};
            checks++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_cmd obs=%h exp=none", o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert (o === e && m[1] === 1'b0) else begin
                    fails++;
                    $error("FAIL cmd_trace obs=%h odt=%b exp=%h", o, m[1], e);
                end
            end
            if (m[21:19] == 3'b000 && m[18:16] == 3'd0 && m[10]) mr_cyc = cyc;
            last_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(negedge clk_0); #1; end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_trace(input int first);
        exp_q.push_back('{3'b010, 3'd0, 14'h0400, 32'(first)});
        exp_q.push_back('{3'b000, 3'd2, 14'h0000, 32'd4});
        exp_q.push_back('{3'b000, 3'd3, 14'h0000, 32'd2});
        exp_q.push_back('{3'b000, 3'd1, 14'h0044, 32'd2});
        exp_q.push_back('{3'b000, 3'd0, 14'h0732, 32'd2});
        exp_q.push_back('{3'b010, 3'd0, 14'h0400, 32'd2});
        exp_q.push_back('{3'b001, 3'd0, 14'h0000, 32'd4});
        exp_q.push_back('{3'b001, 3'd0, 14'h0000, 32'd26});
        exp_q.push_back('{3'b000, 3'd0, 14'h0632, 32'd26});
        exp_q.push_back('{3'b000, 3'd1, 14'h03C4, 32'd2});
        exp_q.push_back('{3'b000, 3'd1, 14'h0044, 32'd2});
    endtask

    task automatic wait_cke(input string tag, input int want);
        for (int n = 0; n < want + 10 && !m[23]; n++) begin
            chk({tag, "_cs_n_pwrup"}, 64'(m[22]), 64'd1);
            step(1);
        end
        chk(tag, 64'(cyc - r), 64'(want));
    endtask

    task automatic wait_done(input string tag, input int want);
        for (int n = 0; n < 2000 && !m[0]; n++) step(1);
        chk(tag, 64'(cyc - mr_cyc), 64'(want));
        chk({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_nop_idle"}, 64'(m[22:0]), 64'({1'b0, 3'b111, 3'b000, 14'h0, 1'b0, 1'b1}));
    endtask

    task automatic wait_ncmd(input int n);
        for (int k = 0; k < 2000 && ncmd < n; k++) step(1);
        chk("ncmd_reached", 64'(ncmd >= n), 64'd1);
    endtask

    initial begin
        int base;
        step(3);
        chk("reset_outputs_u1", 64'(ob1), 64'(RST_OUT));
        chk("reset_outputs_u0", 64'(ob0), 64'(RST_OUT));
        push_trace(20);
        rst1 = 1'b1;
        r = cyc;
        wait_cke("u1_cke_rise", 100);
        wait_done("u1_done_dll10", 65);
        step(5);
        chk("u1_done_sticky", 64'(m[0]), 64'd1);
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        chk("u1_init_req_reset", 64'(ob1), 64'(RST_OUT));
        r = cyc;
        base = ncmd;
        push_trace(20);
        wait_cke("u1_rerun_cke_rise", 100);
        wait_ncmd(base + 8);
        req1 = 1'b1;
        step(1);
        req1 = 1'b0;
        wait_done("u1_rerun_done", 65);
        base = ncmd;
        rst1 = 1'b0;
        step(1);
        rst1 = 1'b1;
        r = cyc;
        push_trace(20);
        wait_cke("u1_rst_cke_rise", 100);
        wait_ncmd(base + 7);
        step(3);
        rst1 = 1'b0;
        #1;
        chk("u1_async_reset_ref1", 64'(ob1), 64'(RST_OUT));
        exp_q.delete();
        step(2);
        rst1 = 1'b1;
        r = cyc;
        push_trace(20);
        wait_cke("u1_restart_cke_rise", 100);
        wait_done("u1_restart_done", 65);
        rst1 = 1'b0;
        step(1);
        sel = 1'b0;
        chk("u0_still_reset", 64'(ob0), 64'(RST_OUT));
        push_trace(80);
        rst0 = 1'b1;
        r = cyc;
        wait_cke("u0_cke_rise_40000", 40000);
        wait_done("u0_done_dll200", 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
